pgen_multi: RTL and testbench

- Multi-mode test-pattern generator feeding the RGB-panel frame-buffer write port.
- Fills the back buffer row by row (write columns, store row, swap) and then requests a frame swap.
- Successor to the single-pattern generator. Adds run-time selectable patterns, a solid/key colour input, a programmable animation rate and pause.
- Supports any power-of-2 geometry and 8/16/24-bit pixel depth.

---
 rtl/pgen_multi.sv | 163 ++++++++++++++++
 tb/tb_pgen_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pgen_multi.sv
// Multi-mode test-pattern generator for the RGB-panel frame buffer.
// Fills the back buffer row by row, then requests a frame swap.
module pgen_multi #(
  parameter int N_ROWS     = 64,
  parameter int N_COLS     = 64,
  parameter int BITDEPTH   = 24,
  parameter int FRAME_DIV  = 1,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [23:0]           cfg_color,
  input  logic [2:0]            cfg_sq,
  input  logic                  cfg_pause,
  output logic [LOG_N_ROWS-1:0] fbw_row_addr,
  output logic                  fbw_row_store,
  input  logic                  fbw_row_rdy,
  output logic                  fbw_row_swap,
  output logic [BITDEPTH-1:0]   fbw_data,
  output logic [LOG_N_COLS-1:0] fbw_col_addr,
  output logic                  fbw_wren,
  output logic                  frame_swap,
  input  logic                  frame_rdy
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {WAIT_FRAME, GEN_ROW, WRITE_ROW, WAIT_ROW} state_t;

  state_t                state, state_nxt;
  logic [LOG_N_ROWS-1:0] cnt_row;
  logic [LOG_N_COLS-1:0] cnt_col;
  logic [11:0]           anim;
  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            mode_q;
  logic [23:0]           color_q;
  logic [2:0]            sq_q;

  // Geometry is a power of two, so "last column/row" is simply all ones.
  always_comb begin
    state_nxt     = state;
    fbw_wren      = 1'b0;
    fbw_row_store = 1'b0;
    fbw_row_swap  = 1'b0;
    frame_swap    = 1'b0;
    case (state)
      WAIT_FRAME: if (frame_rdy) state_nxt = GEN_ROW;
      GEN_ROW: begin
        fbw_wren = 1'b1;
        if (&cnt_col) state_nxt = WRITE_ROW;
      end
      WRITE_ROW: if (fbw_row_rdy) begin
        fbw_row_store = 1'b1;
        fbw_row_swap  = 1'b1;
        state_nxt     = (&cnt_row) ? WAIT_ROW : GEN_ROW;
      end
      WAIT_ROW: if (fbw_row_rdy) begin
        frame_swap = 1'b1;
        state_nxt  = WAIT_FRAME;
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_FRAME;
      cnt_row <= '0;
      cnt_col <= '0;
      anim    <= '0;
      div_cnt <= '0;
      mode_q  <= '0;
      color_q <= '0;
      sq_q    <= '0;
    end else begin
      state <= state_nxt;
      // Config is frozen for the whole frame once generation starts.
      if (state == WAIT_FRAME && frame_rdy) begin
        mode_q  <= cfg_mode;
        color_q <= cfg_color;
        sq_q    <= cfg_sq;
      end
      if (fbw_wren)      cnt_col <= cnt_col + 1'b1;
      if (fbw_row_store) cnt_row <= cnt_row + 1'b1;
      if (frame_swap && !cfg_pause) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          anim    <= anim + 12'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign fbw_row_addr = cnt_row;
  assign fbw_col_addr = cnt_col;

  logic [7:0]  r, g, b;
  logic [7:0]  col_rep, row_rep, g0, g1;
  logic [15:0] col_w, row_w, chk;
  logic [3:0]  c0, c1, a0, a1;
  logic [2:0]  bar;

  // Zero-extended coordinates let narrow geometries use col[3:0]/row[3:0].
  always_comb begin
    col_w = 16'(cnt_col);
    row_w = 16'(cnt_row);
    for (int i = 0; i < 8; i++) begin
      col_rep[7-i] = cnt_col[LOG_N_COLS-1-(i % LOG_N_COLS)];
      row_rep[7-i] = cnt_row[LOG_N_ROWS-1-(i % LOG_N_ROWS)];
    end
    c0  = anim[7:4];
    c1  = c0 + 4'd1;
    a0  = 4'd15 - anim[3:0];
    a1  = anim[3:0];
    g0  = (col_w[3:0] == c0 || row_w[3:0] == c0) ? {a0, a0} : 8'h00;
    g1  = (col_w[3:0] == c1 || row_w[3:0] == c1) ? {a1, a1} : 8'h00;
    chk = (col_w >> sq_q) ^ (row_w >> sq_q);
    bar = cnt_col[LOG_N_COLS-1 -: 3] + anim[2:0];
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    case (mode_q)
      2'd0: begin
        r = col_rep;
        g = g0 + g1;
        b = row_rep;
      end
      2'd1: {r, g, b} = color_q;
      2'd2: {r, g, b} = chk[0] ? 24'hFFFFFF : color_q;
      // Bar order white..black maps each channel to an inverted bar bit.
      default: begin
        r = {8{~bar[1]}};
        g = {8{~bar[2]}};
        b = {8{~bar[0]}};
      end
    endcase
  end

  logic unused_anim;
  assign unused_anim = ^anim[11:8];

  generate
    if (BITDEPTH == 24) begin : g_pack24
      assign fbw_data = {r, g, b};
    end else if (BITDEPTH == 16) begin : g_pack16
      logic unused_lsb;
      assign unused_lsb = ^{r[2:0], g[1:0], b[2:0]};
      assign fbw_data   = {r[7:3], g[7:2], b[7:3]};
    end else if (BITDEPTH == 8) begin : g_pack8
      logic unused_lsb;
      assign unused_lsb = ^{r[4:0], g[4:0], b[5:0]};
      assign fbw_data   = {r[7:5], g[7:5], b[7:6]};
    end else begin : g_bad_depth
      $error("pgen_multi: BITDEPTH must be 8, 16 or 24");
    end
  endgenerate

endmodule

// File: tb/tb_pgen_multi.sv
// Directed bench for pgen_multi: an 8x8 24-bit instance and an 8x8 16-bit
// instance with FRAME_DIV=2 share stimulus; captured pixels are checked by hand values.
module tb_pgen_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [23:0] cfg_color = 24'h0;
  logic [2:0]  cfg_sq = 3'd0;
  logic        cfg_pause = 1'b0;
  logic        fbw_row_rdy = 1'b1;
  logic        frame_rdy = 1'b0;

  logic [2:0]  a_row_addr, a_col_addr, b_row_addr, b_col_addr;
  logic        a_store, a_row_swap, a_wren, a_frame_swap;
  logic        b_store, b_row_swap, b_wren, b_frame_swap;
  logic [23:0] a_data;
  logic [15:0] b_data;

  pgen_multi #(.N_ROWS(8), .N_COLS(8), .BITDEPTH(24), .FRAME_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_color(cfg_color),
    .cfg_sq(cfg_sq), .cfg_pause(cfg_pause), .fbw_row_addr(a_row_addr),
    .fbw_row_store(a_store), .fbw_row_rdy(fbw_row_rdy), .fbw_row_swap(a_row_swap),
    .fbw_data(a_data), .fbw_col_addr(a_col_addr), .fbw_wren(a_wren),
    .frame_swap(a_frame_swap), .frame_rdy(frame_rdy)
  );

  pgen_multi #(.N_ROWS(8), .N_COLS(8), .BITDEPTH(16), .FRAME_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_color(cfg_color),
    .cfg_sq(cfg_sq), .cfg_pause(cfg_pause), .fbw_row_addr(b_row_addr),
    .fbw_row_store(b_store), .fbw_row_rdy(fbw_row_rdy), .fbw_row_swap(b_row_swap),
    .fbw_data(b_data), .fbw_col_addr(b_col_addr), .fbw_wren(b_wren),
    .frame_swap(b_frame_swap), .frame_rdy(frame_rdy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          t0 = 0, t1 = 0;
  int          fr_wren = 0, fr_store = 0, fr_swap = 0;
  logic [7:0]  fr_mask = 8'h0;
  logic [23:0] pix_a [8][8];
  logic [15:0] pix_b [8][8];

  always @(posedge clk) cyc++;

  // Per-frame bookkeeping restarts whenever pixel (0,0) is written.
  always @(negedge clk) begin
    if (a_wren) begin
      pix_a[a_row_addr][a_col_addr] = a_data;
      if (a_row_addr == 3'd0 && a_col_addr == 3'd0) begin
        t0 = cyc; fr_wren = 0; fr_store = 0; fr_swap = 0; fr_mask = 8'h0;
      end
      fr_wren++;
    end
    if (b_wren) pix_b[b_row_addr][b_col_addr] = b_data;
    if (a_store) begin
      fr_store++;
      fr_mask[a_row_addr] = 1'b1;
    end
    if (a_frame_swap) begin
      fr_swap++;
      t1 = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one frame with both ready inputs high; optionally changes cfg_mode
  // once row chg_row starts. Returns the first written {row,col}.
  task automatic applyStimulus(input int chg_row, input logic [1:0] chg_mode,
                               output int first_pos);
    int n;
    frame_rdy = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_wren && n < 100);
    frame_rdy = 1'b0;
    first_pos = int'({a_row_addr, a_col_addr});
    if (!a_wren) checkOutput("frame_start_timeout", 0, 1);
    n = 0;
    while (!a_frame_swap && n < 1000) begin
      if (chg_row >= 0 && a_wren && int'(a_row_addr) == chg_row) cfg_mode = chg_mode;
      @(negedge clk);
      n++;
    end
    if (!a_frame_swap) checkOutput("frame_end_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  logic [23:0] row0_exp [8];
  logic [15:0] bars_exp [4];
  int          first, bad, n;

  initial begin
    row0_exp = '{24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};
    bars_exp = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0};

    repeat (3) @(negedge clk);
    checkOutput("rst_wren", a_wren, 0);
    checkOutput("rst_store", a_store, 0);
    checkOutput("rst_row_swap", a_row_swap, 0);
    checkOutput("rst_frame_swap", a_frame_swap, 0);
    checkOutput("rst_col_addr", a_col_addr, 0);
    checkOutput("rst_row_addr", a_row_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode 0 with anim = 0
    cfg_mode = 2'd0;
    applyStimulus(-1, 2'd0, first);
    checkOutput("m0_r0c0", pix_a[0][0], 24'h00FF00);
    checkOutput("m0_r0c5", pix_a[0][5], 24'hB6FF00);
    checkOutput("m0_r1c1", pix_a[1][1], 24'h240024);
    checkOutput("m0_r2c0", pix_a[2][0], 24'h00FF49);
    checkOutput("m0_r3c3", pix_a[3][3], 24'h6D006D);

    // Mode 1 solid colour, full frame accounting
    cfg_mode = 2'd1; cfg_color = 24'h123456;
    applyStimulus(-1, 2'd0, first);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (pix_a[r][c] !== 24'h123456) bad++;
    checkOutput("m1_bad_pixels", bad, 0);
    checkOutput("m1_pack16", pix_b[4][4], 16'h11AA);
    checkOutput("m1_wren_count", fr_wren, 64);
    checkOutput("m1_store_count", fr_store, 8);
    checkOutput("m1_store_rows", fr_mask, 8'hFF);
    checkOutput("m1_frame_swaps", fr_swap, 1);
    checkOutput("m1_frame_time", t1 - t0 + 1, 73);

    // Mode 2 checker, 2-pixel squares
    cfg_mode = 2'd2; cfg_color = 24'h000000; cfg_sq = 3'd1;
    applyStimulus(-1, 2'd0, first);
    bad = 0;
    for (int c = 0; c < 8; c++) if (pix_a[0][c] !== row0_exp[c]) bad++;
    checkOutput("m2_row0_bad", bad, 0);
    bad = 0;
    for (int c = 0; c < 8; c++) if (pix_a[2][c] !== (row0_exp[c] ^ 24'hFFFFFF)) bad++;
    checkOutput("m2_row2_bad", bad, 0);
    checkOutput("m2_r1c2", pix_a[1][2], 24'hFFFFFF);

    // Mode change mid-frame only affects the next frame
    cfg_mode = 2'd1; cfg_color = 24'h123456;
    applyStimulus(3, 2'd2, first);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (pix_a[r][c] !== 24'h123456) bad++;
    checkOutput("chg_same_frame_bad", bad, 0);
    applyStimulus(-1, 2'd0, first);
    checkOutput("chg_next_r0c0", pix_a[0][0], 24'h123456);
    checkOutput("chg_next_r0c2", pix_a[0][2], 24'hFFFFFF);
    checkOutput("chg_next_r2c0", pix_a[2][0], 24'hFFFFFF);

    // Row-ready stall in WRITE_ROW
    fbw_row_rdy = 1'b0; frame_rdy = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_wren && n < 100);
    frame_rdy = 1'b0;
    n = 0;
    while (a_wren && n < 100) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (a_store || a_row_swap || a_wren || a_row_addr != 3'd0) bad++;
    end
    checkOutput("stall_write_quiet", bad, 0);
    fbw_row_rdy = 1'b1; #1;
    checkOutput("stall_store_strobe", {a_store, a_row_swap}, 2'b11);
    checkOutput("stall_store_row", a_row_addr, 0);
    @(negedge clk);
    checkOutput("stall_store_single", {a_store, a_wren, a_row_addr}, {1'b0, 1'b1, 3'd1});

    // Row-ready stall in WAIT_ROW
    n = 0;
    while (!(a_store && a_row_addr == 3'd7) && n < 200) begin @(negedge clk); n++; end
    checkOutput("row7_store_seen", a_store, 1);
    @(posedge clk); #1;
    fbw_row_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_frame_swap || a_store || a_wren) bad++;
    end
    checkOutput("stall_waitrow_quiet", bad, 0);
    fbw_row_rdy = 1'b1; #1;
    checkOutput("stall_frame_swap", a_frame_swap, 1);
    @(negedge clk);
    checkOutput("stall_frame_swap_single", a_frame_swap, 0);
    @(posedge clk); #1;

    // Reset in the middle of a row
    cfg_mode = 2'd0; frame_rdy = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_wren && n < 100);
    frame_rdy = 1'b0;
    n = 0;
    while (!(a_wren && a_col_addr == 3'd5) && n < 100) begin @(negedge clk); n++; end
    checkOutput("mid_row_col5_seen", a_col_addr, 5);
    rst_n = 1'b0; #1;
    checkOutput("midrst_wren", a_wren, 0);
    checkOutput("midrst_addrs", {a_row_addr, a_col_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (5) begin @(negedge clk); if (a_wren || a_store) bad++; end
    checkOutput("postrst_idle", bad, 0);
    @(posedge clk); #1;
    applyStimulus(-1, 2'd0, first);
    checkOutput("postrst_first_pos", first, 0);
    checkOutput("postrst_r1c1_anim0", pix_a[1][1], 24'h240024);
    checkOutput("postrst_r0c5_anim0", pix_a[0][5], 24'hB6FF00);
    checkOutput("postrst_store_count", fr_store, 8);

    // Mode 3 colour bars on the 16-bit, FRAME_DIV=2 instance
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_mode = 2'd3; cfg_pause = 1'b0;
    for (int f = 0; f < 4; f++) begin
      applyStimulus(-1, 2'd0, first);
      checkOutput($sformatf("bars_f%0d_c0", f), pix_b[0][0], bars_exp[f]);
      if (f == 0) checkOutput("bars_f0_c7", pix_b[0][7], 16'h0000);
      if (f == 2) checkOutput("bars_f2_c4", pix_b[0][4], 16'hF800);
    end
    cfg_pause = 1'b1;
    for (int f = 0; f < 4; f++) begin
      applyStimulus(-1, 2'd0, first);
      checkOutput($sformatf("bars_pause%0d_c0", f), pix_b[0][0], 16'h07FF);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
